// File: rtl/dram_read_engine_if.sv
// Request/response and AXI4 read-channel bundle for dram_read_engine.
// master = the engine, slave = the pipeline plus DDR port it serves.
interface dram_read_engine_if #(
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 128
);
    logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr;
    logic [7:0]                 dram_read_len;
    logic                       dram_read_en;
    logic [DRAM_DATA_WIDTH-1:0] dram_read_data;
    logic                       dram_read_data_valid;
    logic                       dram_read_busy;
    logic [2:0]                 dram_read_error;
    logic                       dram_read_error_clear;

    logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]                 m_axi_arlen;
    logic [2:0]                 m_axi_arsize;
    logic [1:0]                 m_axi_arburst;
    logic                       m_axi_arvalid;
    logic                       m_axi_arready;
    logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]                 m_axi_rresp;
    logic                       m_axi_rlast;
    logic                       m_axi_rvalid;
    logic                       m_axi_rready;

    modport master (
        input  dram_read_addr, dram_read_len, dram_read_en, dram_read_error_clear,
        output dram_read_data, dram_read_data_valid, dram_read_busy, dram_read_error,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output dram_read_addr, dram_read_len, dram_read_en, dram_read_error_clear,
        input  dram_read_data, dram_read_data_valid, dram_read_busy, dram_read_error,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/dram_read_engine.sv
// AXI4 read master for the image pipeline: one request becomes one or two INCR
// bursts (split at the 4 KB boundary), returned beats are streamed out one per clock.
//
// state | meaning
// IDLE  | waiting for dram_read_en
// ADDR  | AR presented, holding fields until arready
// DATA  | accepting R beats of the current burst
module dram_read_engine #(
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 128
) (
    input  logic               clk_pixel,
    input  logic               dram_reader_reset,
    dram_read_engine_if.master bus
);
    localparam int BEAT_BYTES = DRAM_DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [DRAM_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                 r_len;
    logic [8:0]                 r_remain;
    logic [7:0]                 r_beat_cnt;
    logic [DRAM_DATA_WIDTH-1:0] r_data;
    logic                       r_data_valid;
    logic [2:0]                 r_error;

    logic [DRAM_ADDR_WIDTH-1:0] w_addr_al;
    logic [8:0]                 w_total;
    logic [12:0]                w_room_bytes;
    logic [12:0]                w_room;
    logic [8:0]                 w_burst;
    logic [8:0]                 w_remain;
    logic                       w_ar_hs;
    logic                       w_r_hs;
    logic                       w_beat_last;
    logic [2:0]                 w_err_set;
    logic [BEAT_SHIFT-1:0]      w_unused_addr_lsb;

    assign w_unused_addr_lsb = bus.dram_read_addr[BEAT_SHIFT-1:0];
    assign w_addr_al    = {bus.dram_read_addr[DRAM_ADDR_WIDTH-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
    assign w_total      = {1'b0, bus.dram_read_len} + 9'd1;
    assign w_room_bytes = 13'h1000 - {1'b0, w_addr_al[11:0]};
    assign w_room       = w_room_bytes >> BEAT_SHIFT;
    // room only truncates when it is smaller than total, so it always fits 9 bits
    assign w_burst      = ({4'b0, w_total} <= w_room) ? w_total : w_room[8:0];
    assign w_remain     = w_total - w_burst;

    assign w_ar_hs     = (r_state == ADDR) && bus.m_axi_arready;
    assign w_r_hs      = (r_state == DATA) && bus.m_axi_rvalid;
    assign w_beat_last = (r_beat_cnt == 8'd0);

    assign w_err_set[0] = w_r_hs && (bus.m_axi_rresp != 2'b00);
    assign w_err_set[1] = w_r_hs && (bus.m_axi_rlast != w_beat_last);
    assign w_err_set[2] = bus.dram_read_en && (r_state != IDLE);

    always_ff @(posedge clk_pixel or posedge dram_reader_reset) begin
        if (dram_reader_reset) r_state <= IDLE;
        else                   r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.dram_read_en) w_state_nxt = ADDR;
            ADDR:    if (bus.m_axi_arready) w_state_nxt = DATA;
            DATA:    if (w_r_hs && w_beat_last) w_state_nxt = (r_remain != 9'd0) ? ADDR : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge dram_reader_reset) begin
        if (dram_reader_reset) begin
            r_addr       <= '0;
            r_len        <= '0;
            r_remain     <= '0;
            r_beat_cnt   <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_error      <= '0;
        end else begin
            r_data_valid <= w_r_hs;
            if (w_r_hs) r_data <= bus.m_axi_rdata;
            // a fresh error event survives a coincident clear
            r_error <= (bus.dram_read_error_clear ? 3'b000 : r_error) | w_err_set;
            case (r_state)
                IDLE: if (bus.dram_read_en) begin
                    r_addr   <= w_addr_al;
                    r_len    <= 8'(w_burst - 9'd1);
                    r_remain <= w_remain;
                end
                ADDR: if (w_ar_hs) r_beat_cnt <= r_len;
                DATA: if (w_r_hs) begin
                    if (w_beat_last) begin
                        if (r_remain != 9'd0) begin
                            r_addr   <= r_addr + (DRAM_ADDR_WIDTH'({1'b0, r_len} + 9'd1) << BEAT_SHIFT);
                            r_len    <= 8'(r_remain - 9'd1);
                            r_remain <= 9'd0;
                        end
                    end else begin
                        r_beat_cnt <= r_beat_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.m_axi_araddr  = r_addr;
    assign bus.m_axi_arlen   = r_len;
    assign bus.m_axi_arsize  = 3'(BEAT_SHIFT);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = (r_state == ADDR);
    assign bus.m_axi_rready  = (r_state == DATA);

    assign bus.dram_read_data       = r_data;
    assign bus.dram_read_data_valid = r_data_valid;
    assign bus.dram_read_busy       = (r_state != IDLE);
    assign bus.dram_read_error      = r_error;
endmodule

// File: tb/tb_dram_read_engine.sv
// Scoreboard bench for dram_read_engine: a request model predicts AR bursts and
// data beats, an AXI slave model answers, and a monitor checks every output beat.
`timescale 1ns/1ps
module tb_dram_read_engine;
    localparam int AW = 39;
    localparam int DW = 128;
    localparam int LIMIT = 3000;

    logic clk_pixel = 1'b0;
    logic dram_reader_reset = 1'b1;
    always #5 clk_pixel = ~clk_pixel;

    dram_read_engine_if #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) bus ();

    dram_read_engine #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) dut (
        .clk_pixel         (clk_pixel),
        .dram_reader_reset (dram_reader_reset),
        .bus               (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0]  exp_ar_addr[$];
    logic [7:0]     exp_ar_len[$];
    logic [DW-1:0]  exp_data[$];
    logic [2:0]     exp_err;

    int rv_pct = 100;
    int ar_delay = 0;
    int inj_resp_beat = -1;
    int inj_rlast_beat = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = a[35:4];
        return {x ^ 32'hA5A5_0F0F, ~x, x * 32'd2654435761, {a[38:36], 29'h0} ^ x};
    endfunction

    // Reference: walk the request in 4 KB pages, one burst per page touched.
    task automatic expect_req(input logic [AW-1:0] a_in, input logic [7:0] l);
        logic [AW-1:0] a;
        int total, room, n;
        a = {a_in[AW-1:4], 4'h0};
        total = int'(l) + 1;
        while (total > 0) begin
            room = (4096 - int'(a[11:0])) / 16;
            n = (total < room) ? total : room;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(8'(n - 1));
            for (int i = 0; i < n; i++) exp_data.push_back(mem_word(a + AW'(16 * i)));
            a = a + AW'(16 * n);
            total -= n;
        end
    endtask

    // AXI slave model: decides at negedge what the next rising edge will see.
    initial begin : slave
        logic [AW-1:0] sq_addr[$];
        logic [7:0]    sq_len[$];
        int beat;
        int ar_wait;
        bit ar_active;
        beat = 0; ar_wait = 0; ar_active = 0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk_pixel);
            bus.m_axi_arready = 1'b0;
            bus.m_axi_rvalid  = 1'b0;
            bus.m_axi_rlast   = 1'b0;
            bus.m_axi_rresp   = 2'b00;
            if (dram_reader_reset) begin
                sq_addr.delete(); sq_len.delete();
                beat = 0; ar_active = 0;
            end else begin
                if (sq_addr.size() > 0 && int'($urandom_range(0, 99)) < rv_pct) begin
                    bus.m_axi_rvalid = 1'b1;
                    bus.m_axi_rdata  = mem_word(sq_addr[0] + AW'(16 * beat));
                    bus.m_axi_rresp  = (beat == inj_resp_beat) ? 2'b10 : 2'b00;
                    bus.m_axi_rlast  = (beat == int'(sq_len[0])) ^ (beat == inj_rlast_beat);
                    if (bus.m_axi_rready) begin
                        beat++;
                        if (beat > int'(sq_len[0])) begin
                            void'(sq_addr.pop_front());
                            void'(sq_len.pop_front());
                            beat = 0;
                        end
                    end
                end
                if (bus.m_axi_arvalid) begin
                    if (!ar_active) begin
                        ar_active = 1;
                        ar_wait = (ar_delay >= 0) ? ar_delay : int'($urandom_range(0, 3));
                    end
                    chk("ar_expected", 1'(exp_ar_addr.size() > 0), 1'b1);
                    if (ar_wait > 0) begin
                        ar_wait--;
                        if (exp_ar_addr.size() > 0) begin
                            chk("ar_hold_addr", bus.m_axi_araddr, exp_ar_addr[0]);
                            chk("ar_hold_len", bus.m_axi_arlen, exp_ar_len[0]);
                        end
                    end else begin
                        bus.m_axi_arready = 1'b1;
                        ar_active = 0;
                        if (exp_ar_addr.size() > 0) begin
                            chk("araddr", bus.m_axi_araddr, exp_ar_addr.pop_front());
                            chk("arlen", bus.m_axi_arlen, exp_ar_len.pop_front());
                        end
                        chk("arsize", bus.m_axi_arsize, 3'd4);
                        chk("arburst", bus.m_axi_arburst, 2'b01);
                        sq_addr.push_back(bus.m_axi_araddr);
                        sq_len.push_back(bus.m_axi_arlen);
                    end
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk_pixel);
            if (!dram_reader_reset && bus.dram_read_data_valid) begin
                chk("data_expected", 1'(exp_data.size() > 0), 1'b1);
                if (exp_data.size() > 0) chk("data", bus.dram_read_data, exp_data.pop_front());
            end
        end
    end

    task automatic issue_req(input logic [AW-1:0] a, input logic [7:0] l);
        @(negedge clk_pixel);
        bus.dram_read_addr = a;
        bus.dram_read_len  = l;
        bus.dram_read_en   = 1'b1;
        expect_req(a, l);
        @(negedge clk_pixel);
        bus.dram_read_en = 1'b0;
        chk("busy_n1", bus.dram_read_busy, 1'b1);
        chk("arvalid_n1", bus.m_axi_arvalid, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (bus.dram_read_busy && cyc < LIMIT) begin
            @(negedge clk_pixel);
            cyc++;
        end
        chk({name, "_in_time"}, 1'(cyc < LIMIT), 1'b1);
        chk({name, "_valid_at_busy_fall"}, bus.dram_read_data_valid, 1'b1);
        @(negedge clk_pixel);
        chk({name, "_drained"}, 1'(exp_data.size() == 0 && exp_ar_addr.size() == 0), 1'b1);
        chk({name, "_error"}, bus.dram_read_error, exp_err);
    endtask

    task automatic wait_rready(input string name);
        int cyc;
        cyc = 0;
        while (!bus.m_axi_rready && cyc < 100) begin
            @(negedge clk_pixel);
            cyc++;
        end
        chk({name, "_rready_seen"}, bus.m_axi_rready, 1'b1);
    endtask

    initial begin : main
        logic [AW-1:0] ra;
        bus.dram_read_addr = '0;
        bus.dram_read_len = '0;
        bus.dram_read_en = 1'b0;
        bus.dram_read_error_clear = 1'b0;
        exp_err = 3'b000;

        repeat (3) @(negedge clk_pixel);
        chk("rst_busy", bus.dram_read_busy, 1'b0);
        chk("rst_arvalid", bus.m_axi_arvalid, 1'b0);
        chk("rst_rready", bus.m_axi_rready, 1'b0);
        chk("rst_valid", bus.dram_read_data_valid, 1'b0);
        chk("rst_data", bus.dram_read_data, '0);
        chk("rst_error", bus.dram_read_error, 3'b000);
        chk("rst_araddr", bus.m_axi_araddr, '0);
        chk("rst_arlen", bus.m_axi_arlen, 8'd0);
        chk("rst_arsize", bus.m_axi_arsize, 3'd4);
        chk("rst_arburst", bus.m_axi_arburst, 2'b01);
        dram_reader_reset = 1'b0;

        issue_req(39'h1000, 8'd3);
        wait_done("single");
        issue_req(39'h0FC0, 8'd7);
        wait_done("split");

        ar_delay = 5;
        issue_req(39'h1005, 8'd0);
        wait_done("ar_stall");
        ar_delay = 0;

        inj_resp_beat = 1;
        exp_err[0] = 1'b1;
        issue_req(39'h2000, 8'd3);
        wait_done("bad_resp");
        inj_resp_beat = -1;
        inj_rlast_beat = 0;
        exp_err[1] = 1'b1;
        issue_req(39'h3000, 8'd3);
        wait_done("early_last");
        inj_rlast_beat = -1;
        issue_req(39'h4000, 8'd1);
        wait_done("sticky");

        issue_req(39'h5000, 8'd15);
        wait_rready("drop");
        bus.dram_read_addr = 39'h9000;
        bus.dram_read_len = 8'd0;
        bus.dram_read_en = 1'b1;
        exp_err[2] = 1'b1;
        @(negedge clk_pixel);
        bus.dram_read_en = 1'b0;
        wait_done("drop");

        issue_req(39'h5800, 8'd15);
        wait_rready("clr_set");
        bus.dram_read_en = 1'b1;
        bus.dram_read_error_clear = 1'b1;
        exp_err = 3'b100;
        @(negedge clk_pixel);
        bus.dram_read_en = 1'b0;
        bus.dram_read_error_clear = 1'b0;
        wait_done("clr_set");

        bus.dram_read_error_clear = 1'b1;
        @(negedge clk_pixel);
        bus.dram_read_error_clear = 1'b0;
        exp_err = 3'b000;
        @(negedge clk_pixel);
        chk("clear_error", bus.dram_read_error, exp_err);

        issue_req(39'h6000, 8'd31);
        wait_rready("rst_mid");
        repeat (3) @(negedge clk_pixel);
        @(posedge clk_pixel);
        #3;
        dram_reader_reset = 1'b1;
        #1;
        chk("rstmid_arvalid", bus.m_axi_arvalid, 1'b0);
        chk("rstmid_rready", bus.m_axi_rready, 1'b0);
        chk("rstmid_busy", bus.dram_read_busy, 1'b0);
        chk("rstmid_valid", bus.dram_read_data_valid, 1'b0);
        exp_ar_addr.delete();
        exp_ar_len.delete();
        exp_data.delete();
        repeat (2) @(negedge clk_pixel);
        dram_reader_reset = 1'b0;
        issue_req(39'h7F80, 8'd15);
        wait_done("after_rst");

        ar_delay = -1;
        for (int k = 0; k < 30; k++) begin
            rv_pct = int'($urandom_range(40, 100));
            ra = AW'({$urandom(), $urandom()});
            issue_req(ra, 8'($urandom_range(0, 255)));
            wait_done("rand");
        end

        repeat (4) @(negedge clk_pixel);
        chk("final_idle", bus.dram_read_busy, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dram_read_engine.md
# dram_read_engine

AXI4 read master that serves the image pipeline's DRAM read request interface (`dram_read_addr` / `dram_read_len` / `dram_read_en` in; `dram_read_data` / `dram_read_data_valid` / `dram_read_busy` out). It converts each request into one or two AXI4 INCR bursts, splitting any request that crosses a 4 KB boundary. It streams returned beats to the image data buffer FIFO, runs on the pixel clock domain, and sits between the image sender and the PS DDR HP port.

## Interface
- `DRAM_ADDR_WIDTH`, 39: request and AXI address width.
- `DRAM_DATA_WIDTH`, 128: data width; beat size BEAT_BYTES = DRAM_DATA_WIDTH/8, BEAT_SHIFT = $clog2(BEAT_BYTES).
- `clk_pixel` in 1: single clock, all logic on rising edge.
- `dram_reader_reset` in 1: asynchronous, active-high reset.
- `dram_read_addr` in DRAM_ADDR_WIDTH: byte start address; low BEAT_SHIFT bits ignored.
- `dram_read_len` in 8: beats minus one (0..255).
- `dram_read_en` in 1: one-cycle request strobe.
- `dram_read_data` out DRAM_DATA_WIDTH: returned beat.
- `dram_read_data_valid` out 1: one-cycle qualifier per beat.
- `dram_read_busy` out 1: request in progress.
- `dram_read_error` out 3: sticky flags; [0] bad RRESP, [1] RLAST mismatch, [2] request dropped while busy.
- `dram_read_error_clear` in 1: synchronous clear of `dram_read_error`.
- `m_axi_araddr` out DRAM_ADDR_WIDTH; `m_axi_arlen` out 8; `m_axi_arsize` out 3; `m_axi_arburst` out 2; `m_axi_arvalid` out 1; `m_axi_arready` in 1.
- `m_axi_rdata` in DRAM_DATA_WIDTH; `m_axi_rresp` in 2; `m_axi_rlast` in 1; `m_axi_rvalid` in 1; `m_axi_rready` out 1.

## Operation
- Constants: `m_axi_arsize` = BEAT_SHIFT; `m_axi_arburst` = 2'b01 (INCR).
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - On `dram_read_en`, latch `addr` = dram_read_addr with low BEAT_SHIFT bits cleared.
  - `total` = dram_read_len + 1 (9-bit).
  - `room` = (4096 - addr[11:0]) >> BEAT_SHIFT (9-bit, 1..256 for 128-bit beats).
  - `burst` = min(total, room); `remain` = total - burst.
  - Go to ADDR.
- **ADDR**
  - Drive `m_axi_arvalid`=1, `m_axi_araddr`=addr, `m_axi_arlen`=burst-1.
  - Hold all AR fields stable until `m_axi_arready`, then go to DATA with beat counter = 0.
- **DATA**
  - `m_axi_rready`=1 for the whole state. Downstream never backpressures: the image sender only requests when its buffer is below prog_full.
  - Each handshake registers rdata into `dram_read_data` and pulses `dram_read_data_valid`.
  - RRESP != 2'b00 sets error[0].
  - `m_axi_rlast` asserted on any beat other than the burst's last, or deasserted on the last, sets error[1]. The counter, not RLAST, ends the burst.
  - On the last beat:
    - if remain != 0: addr += burst << BEAT_SHIFT; burst = remain; remain = 0; go to ADDR.
    - otherwise go to IDLE.
- `dram_read_en` while not IDLE: the request is ignored and error[2] is set.
- `dram_read_error_clear` clears all flags. If it coincides with a new error event, the set wins.
- `dram_read_busy` = (state != IDLE).
- Reset mid-operation: the FSM returns to IDLE immediately and any outstanding AXI burst is abandoned. The whole subsystem must be reset together, so the image FIFOs are flushed on the same reset.

## Timing
- All outputs reset to 0, except the constant `m_axi_arsize` and `m_axi_arburst`.
- Request sampled at edge N: `dram_read_busy`=1 and `m_axi_arvalid`=1 from N+1.
- R handshake at edge M: `dram_read_data` and `dram_read_data_valid` valid during cycle M+1.
- Last beat at edge M: `dram_read_busy`=0 in cycle M+1, coincident with the final `dram_read_data_valid`. A new request can be accepted at M+1.
- Split burst: second ARVALID rises the cycle after the first burst's last beat.
- `m_axi_rready`=0 in IDLE and ADDR.
- Back-to-back beats sustain 1 beat per clock.

## Test plan
- addr 0x1000, len 3, arready immediate, rvalid every cycle → one AR (araddr 0x1000, arlen 3, arsize 4, arburst 1); 4 valid pulses with matching data; busy high N+1 through the last beat, low the cycle after.
- addr 0xFC0, len 7 → AR 0xFC0 arlen 3, then AR 0x1000 arlen 3; 8 data pulses in order; busy stays high across the split.
- addr 0x1005, len 0, arready held low 5 cycles → araddr 0x1000, arlen 0 stable with arvalid high all 5 cycles; one data pulse after the handshake.
- rresp 2'b10 on beat 2 of 4, and rlast early on beat 1 of another burst → error = 3'b011 and sticky; error_clear → 0; the beats are still delivered.
- Second `dram_read_en` during DATA → no new AR, error[2] set; original burst completes unaffected.
- Reset asserted mid-DATA → arvalid, rready, busy, and data_valid all 0 asynchronously; a fresh request after release works normally.
